sonar_sequenciador: RTL and testbench
=====================================

Name: sonar_sequenciador

Overview:
- Control unit that schedules one sonar sweep step at a time.
- Each step: move the servo to the next position, wait for it to settle, fire one distance measurement (with timeout), then send an N_CHARS-character frame through the serial transmitter one character at a time.
- Sits between the top-level `ligar` input and the sonar datapath: it drives the measure/transmit starts, the character select and the position select, and consumes the datapath's done pulses.

Parameters:
- N_POS, 8: number of servo positions swept (2..8).
- SETTLE_CYCLES, 100000000: clocks to wait after each position change (2 s at 50 MHz).
- TIMEOUT_CYCLES, 1500000: maximum clocks to wait for `sensor_pronto` (30 ms).
- N_CHARS, 8: characters per frame (1..8).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- ligar  in  1  level enable; sampled only in INICIAL and AVANCA.
- sensor_pronto  in  1  one-cycle pulse from the measurement datapath: measurement done.
- serial_pronto  in  1  one-cycle pulse from the serial TX: character finished.
- medir  out  1  one-cycle start pulse for the measurement.
- transmitir  out  1  one-cycle start pulse for the serial TX.
- sel_char  out  3  index of the frame character being sent.
- posicao  out  3  current servo position, 0..N_POS-1.
- erro_medida  out  1  high when the last measurement timed out; the datapath sends an error code in place of the distance.
- fim_posicao  out  1  one-cycle pulse when a step's frame is complete.
- db_estado  out  4  state code, for debug display.

Behaviour:
- Reset (reset=0, async) sets:
  - state INICIAL;
  - posicao=0, direction up;
  - sel_char=0, erro_medida=0;
  - both counters=0;
  - all pulse outputs=0.
- All outputs are registered or decoded from the state register (Moore). There are no combinational paths from inputs to outputs.
- States and db_estado codes:
  - INICIAL 0: idle. ligar=1 → PREPARA.
  - PREPARA 1: clear settle counter, timeout counter and sel_char. Always → ESPERA.
  - ESPERA 2: settle counter increments every cycle. → MEDE when the counter reaches SETTLE_CYCLES-1, so the state lasts exactly SETTLE_CYCLES cycles.
  - MEDE 3: medir=1 for this one cycle; clear erro_medida. → AGUARDA_MED.
  - AGUARDA_MED 4: timeout counter increments every cycle.
    - sensor_pronto=1 → TRANSMITE.
    - Counter reaching TIMEOUT_CYCLES-1 → erro_medida<=1, → TRANSMITE.
    - If both happen in the same cycle, sensor_pronto wins and erro_medida stays 0.
  - TRANSMITE 5: transmitir=1 for one cycle. → AGUARDA_TX.
  - AGUARDA_TX 6: wait for serial_pronto=1, then:
    - sel_char==N_CHARS-1 → AVANCA;
    - otherwise sel_char<=sel_char+1 and → TRANSMITE.
  - AVANCA 7: fim_posicao=1 for one cycle; update posicao.
    - ligar=1 → PREPARA.
    - ligar=0 → INICIAL.
- Sweep is ping-pong, 0,1,…,N_POS-1,N_POS-2,…,0,1,…:
  - going up at N_POS-1: flip direction to down, posicao<=N_POS-2;
  - going down at 0: flip direction to up, posicao<=1.
- posicao and direction are held in INICIAL. A re-enable resumes from the held position. Only reset returns them to 0/up.
- Spurious inputs are ignored, with no state change:
  - sensor_pronto outside AGUARDA_MED;
  - serial_pronto outside AGUARDA_TX.
- ligar dropping mid-step does not abort the step; the current frame completes and the block then returns to INICIAL.
- sel_char is stable for the whole transmission of a character, from TRANSMITE through AGUARDA_TX.
- Reset asserted mid-operation returns to INICIAL immediately; any partially sent frame is abandoned.
- Counter widths are $clog2 of the respective parameter. Counters saturate and never wrap inside a state.
- Minimum step latency, from entering PREPARA to the AVANCA pulse: 1 + SETTLE_CYCLES + 1 + (wait for measurement) + N_CHARS×(1 + wait for TX) cycles.

Test Plan:
All scenarios use N_POS=4, SETTLE_CYCLES=10, TIMEOUT_CYCLES=20, N_CHARS=3.
1. Normal step: reset released, ligar=1, sensor_pronto 5 cycles after medir, serial_pronto 4 cycles after each transmitir → medir exactly 12 cycles after ligar seen in INICIAL; transmitir ×3 with sel_char 0,1,2; fim_posicao pulse; posicao 0→1; erro_medida=0.
2. Ping-pong sweep: ligar held high, responders as in 1, run 8 steps → posicao sequence 1,2,3,2,1,0,1,2 and 8 fim_posicao pulses.
3. Timeout: sensor_pronto never asserted → transmitir exactly 20 cycles after leaving MEDE, erro_medida=1 during the whole frame, cleared at the next MEDE.
4. Simultaneous: sensor_pronto on the cycle the timeout counter hits 19 → erro_medida stays 0; exactly one TRANSMITE entry.
5. ligar dropped during AGUARDA_TX of char 1 → chars 1 and 2 still sent, then INICIAL (db_estado=0) with posicao held at 1. Re-asserting ligar → next step ends at posicao 2.
6. Async reset pulse mid AGUARDA_MED, with spurious serial_pronto pulses injected before it → no state change from the spurious pulses; on reset all outputs 0, db_estado=0 without waiting for a clock edge, posicao=0.

Source files
------------

// File: rtl/sonar_sequenciador_if.sv
// rtl/sonar_sequenciador_if.sv - handshake bundle between the sweep sequencer and the sonar datapath
interface sonar_sequenciador_if;
    logic       ligar;
    logic       sensor_pronto;
    logic       serial_pronto;
    logic       medir;
    logic       transmitir;
    logic [2:0] sel_char;
    logic [2:0] posicao;
    logic       erro_medida;
    logic       fim_posicao;
    logic [3:0] db_estado;

    modport master (
        output ligar, sensor_pronto, serial_pronto,
        input  medir, transmitir, sel_char, posicao, erro_medida, fim_posicao, db_estado
    );

    modport slave (
        input  ligar, sensor_pronto, serial_pronto,
        output medir, transmitir, sel_char, posicao, erro_medida, fim_posicao, db_estado
    );
endinterface

// File: rtl/sonar_sequenciador.sv
// rtl/sonar_sequenciador.sv - sonar sweep sequencer: settle, measure with timeout, send frame, step servo
module sonar_sequenciador #(
    parameter int N_POS          = 8,
    parameter int SETTLE_CYCLES  = 100000000,
    parameter int TIMEOUT_CYCLES = 1500000,
    parameter int N_CHARS        = 8
) (
    input  logic               clock,
    input  logic               reset,
    sonar_sequenciador_if.slave bus
);
    typedef enum logic [3:0] {
        INICIAL     = 4'd0,
        PREPARA     = 4'd1,
        ESPERA      = 4'd2,
        MEDE        = 4'd3,
        AGUARDA_MED = 4'd4,
        TRANSMITE   = 4'd5,
        AGUARDA_TX  = 4'd6,
        AVANCA      = 4'd7
    } state_t;

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TOUT_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]    CHAR_LAST   = 3'(N_CHARS - 1);
    localparam logic [2:0]    POS_LAST    = 3'(N_POS - 1);
    localparam logic [2:0]    POS_PENULT  = 3'(N_POS - 2);

    state_t         state, state_next;
    logic [SW-1:0]  settle_cnt;
    logic [TW-1:0]  tout_cnt;
    logic [2:0]     sel_char_r;
    logic [2:0]     pos_r;
    logic           dir_up;
    logic           erro_r;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= INICIAL;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            INICIAL:     if (bus.ligar) state_next = PREPARA;
            PREPARA:     state_next = ESPERA;
            ESPERA:      if (settle_cnt == SETTLE_LAST) state_next = MEDE;
            MEDE:        state_next = AGUARDA_MED;
            AGUARDA_MED: if (bus.sensor_pronto || tout_cnt == TOUT_LAST) state_next = TRANSMITE;
            TRANSMITE:   state_next = AGUARDA_TX;
            AGUARDA_TX:  if (bus.serial_pronto)
                             state_next = (sel_char_r == CHAR_LAST) ? AVANCA : TRANSMITE;
            AVANCA:      state_next = bus.ligar ? PREPARA : INICIAL;
            default:     state_next = INICIAL;
        endcase
    end

    always_comb begin
        bus.medir       = (state == MEDE);
        bus.transmitir  = (state == TRANSMITE);
        bus.fim_posicao = (state == AVANCA);
        bus.db_estado   = state;
        bus.sel_char    = sel_char_r;
        bus.posicao     = pos_r;
        bus.erro_medida = erro_r;
    end

    // Counters stop at their terminal value; the state always leaves on that same cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            settle_cnt <= '0;
            tout_cnt   <= '0;
            sel_char_r <= 3'd0;
            pos_r      <= 3'd0;
            dir_up     <= 1'b1;
            erro_r     <= 1'b0;
        end else begin
            case (state)
                PREPARA: begin
                    settle_cnt <= '0;
                    tout_cnt   <= '0;
                    sel_char_r <= 3'd0;
                end
                ESPERA:
                    if (settle_cnt != SETTLE_LAST) settle_cnt <= settle_cnt + 1'b1;
                MEDE:
                    erro_r <= 1'b0;
                AGUARDA_MED: begin
                    if (tout_cnt != TOUT_LAST) tout_cnt <= tout_cnt + 1'b1;
                    if (!bus.sensor_pronto && tout_cnt == TOUT_LAST) erro_r <= 1'b1;
                end
                AGUARDA_TX:
                    if (bus.serial_pronto && sel_char_r != CHAR_LAST) sel_char_r <= sel_char_r + 3'd1;
                AVANCA: begin
                    // Ping-pong sweep: bounce off either end without repeating the end position.
                    if (dir_up) begin
                        if (pos_r == POS_LAST) begin
                            dir_up <= 1'b0;
                            pos_r  <= POS_PENULT;
                        end else begin
                            pos_r  <= pos_r + 3'd1;
                        end
                    end else begin
                        if (pos_r == 3'd0) begin
                            dir_up <= 1'b1;
                            pos_r  <= 3'd1;
                        end else begin
                            pos_r  <= pos_r - 3'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sonar_sequenciador.sv
// tb/tb_sonar_sequenciador.sv - directed self-checking bench for sonar_sequenciador
module tb_sonar_sequenciador;
    localparam int NC = 3;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   tests = 0;
    int   fails = 0;

    sonar_sequenciador_if sif();

    sonar_sequenciador #(
        .N_POS(4), .SETTLE_CYCLES(10), .TIMEOUT_CYCLES(20), .N_CHARS(NC)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (sif.slave)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic sig_of(input int which);
        case (which)
            0:       return sif.medir;
            1:       return sif.transmitir;
            default: return sif.fim_posicao;
        endcase
    endfunction

    task automatic wait_sig(input int which, input int budget, output int n);
        n = 0;
        while (sig_of(which) !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        if (sig_of(which) !== 1'b1) n = -1;
    endtask

    // One sweep step with datapath responders; sens_dly<0 means the sensor never answers.
    task automatic do_step(input string tag, input int med_lat, input int sens_dly,
                           input bit exp_err, input int drop_char,
                           input logic [2:0] pos_after, input bit exp_idle);
        int n;
        wait_sig(0, 40, n);
        if (med_lat >= 0) chk($sformatf("%s_medir_lat", tag), n, med_lat);
        else              chk($sformatf("%s_medir_seen", tag), 32'(n >= 0), 1);
        tick();
        chk($sformatf("%s_err_clr", tag), sif.erro_medida, 0);
        if (sens_dly > 0) begin
            repeat (sens_dly - 1) tick();
            sif.sensor_pronto = 1'b1;
            tick();
            sif.sensor_pronto = 1'b0;
        end
        for (int c = 0; c < NC; c++) begin
            wait_sig(1, 40, n);
            if (c == 0 && sens_dly < 0) chk($sformatf("%s_tout_lat", tag), n, 20);
            else                        chk($sformatf("%s_tx%0d_seen", tag, c), 32'(n >= 0), 1);
            chk($sformatf("%s_sel%0d", tag, c), sif.sel_char, c);
            chk($sformatf("%s_err%0d", tag, c), sif.erro_medida, exp_err);
            tick();
            chk($sformatf("%s_wait_tx%0d", tag, c), {sif.transmitir, sif.db_estado}, 5'd6);
            if (c == drop_char) sif.ligar = 1'b0;
            repeat (2) tick();
            chk($sformatf("%s_sel_hold%0d", tag, c), sif.sel_char, c);
            tick();
            sif.serial_pronto = 1'b1;
            tick();
            sif.serial_pronto = 1'b0;
        end
        wait_sig(2, 5, n);
        chk($sformatf("%s_fim", tag), 32'(n >= 0), 1);
        tick();
        chk($sformatf("%s_pos", tag), sif.posicao, pos_after);
        chk($sformatf("%s_next_state", tag), sif.db_estado, exp_idle ? 0 : 1);
    endtask

    initial begin
        automatic logic [2:0] sweep [8] = '{3'd1, 3'd2, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1, 3'd2};
        int n;
        sif.ligar = 1'b0;
        sif.sensor_pronto = 1'b0;
        sif.serial_pronto = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        chk("rst_state", sif.db_estado, 0);
        chk("rst_pos", sif.posicao, 0);
        chk("rst_outs", {sif.medir, sif.transmitir, sif.fim_posicao, sif.erro_medida, sif.sel_char}, 0);

        // 1: normal step
        sif.ligar = 1'b1;
        do_step("t1", 12, 5, 1'b0, -1, 3'd1, 1'b0);

        // 2: ping-pong sweep from reset
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int s = 0; s < 8; s++) do_step($sformatf("t2s%0d", s), -1, 5, 1'b0, -1, sweep[s], 1'b0);

        // 3: timeout, then error cleared on the next measurement
        do_step("t3to", -1, -1, 1'b1, -1, 3'd3, 1'b0);
        do_step("t3ok", -1, 5, 1'b0, -1, 3'd2, 1'b0);

        // 4: sensor answer coincides with the last timeout cycle
        do_step("t4", -1, 20, 1'b0, -1, 3'd1, 1'b0);

        // 5: ligar dropped while char 1 is in flight
        reset = 1'b0;
        tick();
        reset = 1'b1;
        do_step("t5", -1, 5, 1'b0, 1, 3'd1, 1'b1);
        repeat (3) tick();
        chk("t5_idle_state", sif.db_estado, 0);
        chk("t5_idle_pos", sif.posicao, 1);
        sif.ligar = 1'b1;
        do_step("t5re", 12, 5, 1'b0, -1, 3'd2, 1'b0);

        // 6: spurious pulses, then async reset mid measurement
        tick();
        sif.sensor_pronto = 1'b1;
        tick();
        sif.sensor_pronto = 1'b0;
        chk("t6_spur_sensor", sif.db_estado, 2);
        wait_sig(0, 40, n);
        chk("t6_medir_seen", 32'(n >= 0), 1);
        repeat (2) tick();
        sif.serial_pronto = 1'b1;
        tick();
        sif.serial_pronto = 1'b0;
        tick();
        sif.serial_pronto = 1'b1;
        tick();
        sif.serial_pronto = 1'b0;
        chk("t6_spur_state", sif.db_estado, 4);
        chk("t6_spur_sel", sif.sel_char, 0);
        chk("t6_pre_pos", sif.posicao, 2);
        #3;
        reset = 1'b0;
        #1;
        chk("t6_async_state", sif.db_estado, 0);
        chk("t6_async_pos", sif.posicao, 0);
        chk("t6_async_outs", {sif.medir, sif.transmitir, sif.fim_posicao, sif.erro_medida, sif.sel_char}, 0);
        tick();
        reset = 1'b1;
        sif.ligar = 1'b0;
        tick();
        chk("t6_after_state", sif.db_estado, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
